// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the fifo write port between two producers.
// Grant is held for a whole burst, capped at MAX_BEATS beats per grant.
module fifo_wr_arbiter #(
  parameter int B         = 8,
  parameter int MAX_BEATS = 4,
  parameter int CW        = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [B-1:0] data0,
  input  logic         last0,
  output logic         ack0,
  input  logic         req1,
  input  logic [B-1:0] data1,
  input  logic         last1,
  output logic         ack1,
  input  logic         full,
  output logic         wr,
  output logic [B-1:0] w_data,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          rr;          // 0 favours producer 0 on contention

  logic cur_last;
  logic other_req;
  logic at_limit;
  logic release_now;

  // NOTE: acceptance is combinational so a beat is taken in the same cycle
  // req is seen; every signal gets a default so no latch is inferred.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    w_data    = '0;
    cur_last  = 1'b0;
    other_req = 1'b0;
    case (state)
      G0: begin
        ack0      = req0 & ~full;
        w_data    = data0;
        cur_last  = last0;
        other_req = req1;
      end
      G1: begin
        ack1      = req1 & ~full;
        w_data    = data1;
        cur_last  = last1;
        other_req = req0;
      end
      default: ;
    endcase
  end

  assign wr          = ack0 | ack1;
  assign grant       = {state == G1, state == G0};
  assign at_limit    = (count == CW'(MAX_BEATS - 1));
  assign release_now = wr & (cur_last | at_limit);

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      rr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) state <= rr ? G1 : G0;
          else if (req0)    state <= G0;
          else if (req1)    state <= G1;
        end
        G0, G1: begin
          if (release_now) begin
            count <= '0;
            rr    <= (state == G0);
            // The accepting producer keeps the port only when it was cut off
            // by the beat limit mid-burst and nobody else is waiting.
            if (other_req)      state <= (state == G0) ? G1 : G0;
            else if (!cur_last) state <= state;
            else                state <= IDLE;
          end else if (wr) begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small behavioural 4-entry fifo.
module tb_fifo_wr_arbiter;

  localparam int B = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
  logic [B-1:0] data0 = '0, data1 = '0;
  logic         ack0, ack1, wr;
  logic [B-1:0] w_data;
  logic [1:0]   grant;
  logic         full = 1'b0;

  logic         rd_en = 1'b0;
  logic [B-1:0] rd_data = '0;
  logic [B-1:0] fq[$];
  logic [B-1:0] log_q[$];

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.B(B), .MAX_BEATS(4), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .full(full), .wr(wr), .w_data(w_data), .grant(grant)
  );

  always #5 clk = ~clk;

  // Fifo model: depth 4, read popped before write pushed on the same edge.
  always @(posedge clk) begin
    if (rd_en && fq.size() > 0) rd_data <= fq.pop_front();
    if (wr) begin
      fq.push_back(w_data);
      log_q.push_back(w_data);
    end
    full <= (fq.size() >= 4);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0; last0 = 0; last1 = 0;
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    rd_en = 1'b1;
    repeat (5) tick();
    rd_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [B-1:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  task automatic beat_chk(input string tag, input logic [1:0] g, input logic w,
                          input logic [B-1:0] d);
    settle();
    check({tag, "_grant"}, grant, g);
    check({tag, "_wr"}, wr, w);
    if (w) check({tag, "_data"}, w_data, d);
    check({tag, "_ack"}, {ack1, ack0}, w ? g : 2'b00);
  endtask

  task automatic log_chk(input string tag, input logic [B-1:0] exp[$]);
    check({tag, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(tag, log_q[i], exp[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset held while requests toggle
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0 = i[0]; req1 = i[1]; data0 = 3'd5; data1 = 3'd6;
      settle();
      check("rst_outs", {grant, wr, ack1, ack0}, 5'b0);
      tick();
    end
    req0 = 0; req1 = 0;
    reset = 1'b1;
    tick();

    // 2: single 3-beat burst from producer 0
    log_q.delete();
    req0 = 1; data0 = 3'd1; last0 = 0;
    beat_chk("t2_idle", 2'b00, 1'b0, 3'd0); tick();
    beat_chk("t2_b1", 2'b01, 1'b1, 3'd1); tick();
    data0 = 3'd2;
    beat_chk("t2_b2", 2'b01, 1'b1, 3'd2); tick();
    data0 = 3'd3; last0 = 1;
    beat_chk("t2_b3", 2'b01, 1'b1, 3'd3); tick();
    req0 = 0; last0 = 0;
    beat_chk("t2_end", 2'b00, 1'b0, 3'd0);
    read_chk("t2_rd1", 3'd1);
    read_chk("t2_rd2", 3'd2);
    read_chk("t2_rd3", 3'd3);

    // 3: simultaneous requests, handoff without gap, then rr favours 1
    do_reset(); drain(); log_q.delete(); rd_en = 1;
    req0 = 1; data0 = 3'd4; last0 = 0;
    req1 = 1; data1 = 3'd6; last1 = 0;
    beat_chk("t3_idle", 2'b00, 1'b0, 3'd0); tick();
    beat_chk("t3_g0b1", 2'b01, 1'b1, 3'd4); tick();
    data0 = 3'd5; last0 = 1;
    beat_chk("t3_g0b2", 2'b01, 1'b1, 3'd5); tick();
    data0 = 3'd1; last0 = 0;
    beat_chk("t3_g1b1", 2'b10, 1'b1, 3'd6); tick();
    data1 = 3'd7; last1 = 1;
    beat_chk("t3_g1b2", 2'b10, 1'b1, 3'd7); tick();
    req1 = 0; last1 = 0; last0 = 1;
    beat_chk("t3_g0c", 2'b01, 1'b1, 3'd1); tick();
    req0 = 0; last0 = 0;
    beat_chk("t3_end", 2'b00, 1'b0, 3'd0);
    log_chk("t3_log", '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1});

    // 4: beat limit cuts producer 0 after 4 beats
    do_reset(); drain(); log_q.delete(); rd_en = 1;
    req0 = 1; data0 = 3'd1; last0 = 0;
    beat_chk("t4_idle", 2'b00, 1'b0, 3'd0); tick();
    req1 = 1; data1 = 3'd7; last1 = 1;
    for (int i = 1; i <= 4; i++) begin
      data0 = B'(i);
      beat_chk("t4_g0", 2'b01, 1'b1, B'(i)); tick();
    end
    data0 = 3'd5;
    beat_chk("t4_g1", 2'b10, 1'b1, 3'd7); tick();
    req1 = 0; last1 = 0;
    beat_chk("t4_g0r5", 2'b01, 1'b1, 3'd5); tick();
    data0 = 3'd6; last0 = 1;
    beat_chk("t4_g0r6", 2'b01, 1'b1, 3'd6); tick();
    req0 = 0; last0 = 0;
    beat_chk("t4_end", 2'b00, 1'b0, 3'd0);
    log_chk("t4_log", '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd6});

    // 5: fifo fills mid-burst; one read lets exactly one beat through
    do_reset(); drain(); log_q.delete(); rd_en = 0;
    req0 = 1; data0 = 3'd1; last0 = 0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      data0 = B'(i);
      beat_chk("t5_fill", 2'b01, 1'b1, B'(i)); tick();
    end
    data0 = 3'd5;
    beat_chk("t5_full1", 2'b01, 1'b0, 3'd0); tick();
    rd_en = 1;
    beat_chk("t5_full2", 2'b01, 1'b0, 3'd0); tick();
    rd_en = 0;
    check("t5_rd1", rd_data, 3'd1);
    beat_chk("t5_resume", 2'b01, 1'b1, 3'd5); tick();
    data0 = 3'd6; last0 = 1;
    beat_chk("t5_full3", 2'b01, 1'b0, 3'd0);
    req0 = 0; last0 = 0;
    beat_chk("t5_drop", 2'b01, 1'b0, 3'd0);
    read_chk("t5_rd2", 3'd2);
    read_chk("t5_rd3", 3'd3);
    read_chk("t5_rd4", 3'd4);
    read_chk("t5_rd5", 3'd5);
    beat_chk("t5_held", 2'b01, 1'b0, 3'd0);
    log_chk("t5_log", '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5});

    // 6: async reset during producer 1's second beat
    do_reset(); drain(); log_q.delete(); rd_en = 1;
    req1 = 1; data1 = 3'd1; last1 = 0;
    tick();
    beat_chk("t6_b1", 2'b10, 1'b1, 3'd1); tick();
    data1 = 3'd2;
    beat_chk("t6_b2", 2'b10, 1'b1, 3'd2);
    reset = 1'b0;
    beat_chk("t6_rst", 2'b00, 1'b0, 3'd0);
    tick();
    reset = 1'b1;
    check("t6_log_len", log_q.size(), 1);
    req0 = 1; data0 = 3'd3; last0 = 1;
    beat_chk("t6_idle", 2'b00, 1'b0, 3'd0); tick();
    beat_chk("t6_rr0", 2'b01, 1'b1, 3'd3); tick();
    req0 = 0; req1 = 0; last0 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
